fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 126 ++++++++++++
 tb/tb_fetch_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: PC with priority-ordered jump/branch/call/ret,
// a return-address stack, sticky halt/error flags and a saturating cycle counter.
module fetch_seq #(
  parameter int PW = 10,
  parameter int OW = 6,
  parameter int SD = 4,
  parameter int CW = 16,
  localparam int DW = $clog2(SD + 1)
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          stall,
  input  logic          jump_en,
  input  logic          branch_en,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic          halt_req,
  input  logic [PW-1:0] target,
  input  logic [OW-1:0] offset,
  output logic [PW-1:0] PC,
  output logic          halt,
  output logic [CW-1:0] cycle_ct,
  output logic [DW-1:0] depth,
  output logic          stack_err
);

  logic [PW-1:0] pc_reg, pc_next;
  logic          halt_reg, halt_next;
  logic [CW-1:0] ct_reg, ct_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          err_reg, err_next;
  logic          push;
  logic [PW-1:0] pc_plus1;
  logic [PW-1:0] off_ext;
  logic [PW-1:0] stack_top;
  logic [PW-1:0] stack_mem [SD];

  assign pc_plus1 = pc_reg + 1'b1;

  always_comb begin
    off_ext = {PW{offset[OW-1]}};
    off_ext[OW-1:0] = offset;
  end

  // Top-of-stack read; an empty stack is caught before this value is used.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < SD; i++) begin
      if (DW'(i) == depth_reg - 1'b1) stack_top = stack_mem[i];
    end
  end

  always_comb begin
    pc_next    = pc_reg;
    halt_next  = halt_reg;
    depth_next = depth_reg;
    err_next   = err_reg;
    push       = 1'b0;
    if (!halt_reg) begin
      if (halt_req) begin
        halt_next = 1'b1;
      end else if (stall) begin
        pc_next = pc_reg;
      end else if (ret_en) begin
        if (depth_reg == '0) begin
          err_next  = 1'b1;
          halt_next = 1'b1;
        end else begin
          pc_next    = stack_top;
          depth_next = depth_reg - 1'b1;
        end
      end else if (call_en) begin
        if (depth_reg == DW'(SD)) begin
          err_next  = 1'b1;
          halt_next = 1'b1;
        end else begin
          push       = 1'b1;
          pc_next    = target;
          depth_next = depth_reg + 1'b1;
        end
      end else if (jump_en) begin
        pc_next = target;
      end else if (branch_en) begin
        pc_next = pc_reg + off_ext;
      end else begin
        pc_next = pc_plus1;
      end
    end
  end

  // Counter runs on every non-halted cycle, including the one that raises halt.
  always_comb begin
    ct_next = ct_reg;
    if (!halt_reg && ct_reg != '1) ct_next = ct_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      pc_reg    <= '0;
      halt_reg  <= 1'b0;
      ct_reg    <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      halt_reg  <= halt_next;
      ct_reg    <= ct_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Stack contents are not cleared by start; depth alone defines validity.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < SD; i++) begin
      if (!start && push && depth_reg == DW'(i)) stack_mem[i] <= pc_plus1;
    end
  end

  assign PC        = pc_reg;
  assign halt      = halt_reg;
  assign cycle_ct  = ct_reg;
  assign depth     = depth_reg;
  assign stack_err = err_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_fetch_seq;
  localparam int PW = 10;
  localparam int OW = 6;
  localparam int SD = 4;
  localparam int CW = 16;
  localparam int DW = $clog2(SD + 1);

  logic          CLK = 1'b0;
  logic          start, stall, jump_en, branch_en, call_en, ret_en, halt_req;
  logic [PW-1:0] target;
  logic [OW-1:0] offset;
  logic [PW-1:0] PC;
  logic          halt;
  logic [CW-1:0] cycle_ct;
  logic [DW-1:0] depth;
  logic          stack_err;

  always #5 CLK = ~CLK;

  fetch_seq #(.PW(PW), .OW(OW), .SD(SD), .CW(CW)) dut (
    .CLK(CLK), .start(start), .stall(stall), .jump_en(jump_en),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
    .halt_req(halt_req), .target(target), .offset(offset), .PC(PC),
    .halt(halt), .cycle_ct(cycle_ct), .depth(depth), .stack_err(stack_err)
  );

  int total = 0;
  int bad = 0;
  int m_pc, m_ct;
  bit m_halt, m_err;
  int m_stk[$];
  bit chk_on = 1'b0;
  int saved_ct;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: priority rules applied to an int PC and a queue stack.
  task automatic model_update();
    int off;
    off = offset[OW-1] ? int'(offset) - (1 << OW) : int'(offset);
    if (start) begin
      m_pc = 0; m_halt = 0; m_ct = 0; m_err = 0; m_stk.delete();
    end else if (!m_halt) begin
      if (m_ct < (1 << CW) - 1) m_ct++;
      if (halt_req) m_halt = 1;
      else if (stall) m_pc = m_pc;
      else if (ret_en) begin
        if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; end
        else m_pc = m_stk.pop_back();
      end else if (call_en) begin
        if (m_stk.size() == SD) begin m_err = 1; m_halt = 1; end
        else begin m_stk.push_back((m_pc + 1) % (1 << PW)); m_pc = int'(target); end
      end else if (jump_en) m_pc = int'(target);
      else if (branch_en) m_pc = (m_pc + off + (1 << PW)) % (1 << PW);
      else m_pc = (m_pc + 1) % (1 << PW);
    end
  endtask

  task automatic drive(bit s, bit st, bit j, bit b, bit c, bit r, bit h,
                       int t, int o);
    start = s; stall = st; jump_en = j; branch_en = b; call_en = c;
    ret_en = r; halt_req = h; target = PW'(t); offset = OW'(o);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
    $display("t=%0t pc=%0d halt=%0d ct=%0d depth=%0d err=%0d",
             $time, PC, halt, cycle_ct, depth, stack_err);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("model_pc", int'(PC), m_pc);
      check("model_halt", int'(halt), int'(m_halt));
      check("model_ct", int'(cycle_ct), m_ct);
      check("model_depth", int'(depth), m_stk.size());
      check("model_err", int'(stack_err), int'(m_err));
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_on = 1'b1;
    check("reset_pc", int'(PC), 0);
    check("reset_ct", int'(cycle_ct), 0);

    // Sequential fetch
    idle();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("seq_pc", int'(PC), k);
    end
    check("seq_ct", int'(cycle_ct), 5);

    // Branch wrap
    drive(0, 0, 1, 0, 0, 0, 0, 2, 0); tick();
    check("jump_pc", int'(PC), 2);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 6'h3D); tick();
    check("wrap_pc", int'(PC), 1023);
    idle(); tick();
    check("wrap_next", int'(PC), 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 5); tick();
    check("branch_pos", int'(PC), 5);
    drive(0, 0, 1, 1, 0, 0, 0, 40, 5); tick();
    check("jump_over_branch", int'(PC), 40);

    // Nested call/return
    drive(0, 0, 1, 0, 0, 0, 0, 10, 0); tick();
    drive(0, 0, 1, 0, 1, 0, 0, 100, 0); tick();
    check("call1_pc", int'(PC), 100);
    drive(0, 0, 0, 0, 1, 0, 0, 200, 0); tick();
    check("call2_depth", int'(depth), 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    check("ret1_pc", int'(PC), 101);
    tick();
    check("ret2_pc", int'(PC), 11);
    check("ret2_depth", int'(depth), 0);

    // Overflow
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 100 * k, 0); tick();
    end
    check("ovf_pc", int'(PC), 400);
    check("ovf_depth", int'(depth), 4);
    check("ovf_err", int'(stack_err), 1);
    check("ovf_halt", int'(halt), 1);
    saved_ct = int'(cycle_ct);
    check("ovf_ct", saved_ct, 5);
    drive(0, 0, 1, 0, 0, 1, 0, 9, 0); tick(); tick(); tick();
    check("ovf_ct_frozen", int'(cycle_ct), saved_ct);
    check("ovf_pc_frozen", int'(PC), 400);

    // Priority + underflow, then start clears everything
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 50, 0); tick();
    drive(0, 0, 1, 0, 0, 1, 0, 77, 0); tick();
    check("unf_pc", int'(PC), 50);
    check("unf_err", int'(stack_err), 1);
    check("unf_halt", int'(halt), 1);
    drive(1, 0, 1, 0, 1, 0, 1, 33, 0); tick();
    check("start_pc", int'(PC), 0);
    check("start_halt", int'(halt), 0);
    check("start_ct", int'(cycle_ct), 0);
    check("start_depth", int'(depth), 0);
    check("start_err", int'(stack_err), 0);

    // Stall then halt_req
    drive(0, 0, 1, 0, 0, 0, 0, 7, 0); tick();
    saved_ct = int'(cycle_ct);
    drive(0, 1, 1, 0, 1, 0, 0, 300, 0);
    tick(); tick(); tick();
    check("stall_pc", int'(PC), 7);
    check("stall_ct", int'(cycle_ct), saved_ct + 3);
    check("stall_depth", int'(depth), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    check("hreq_halt", int'(halt), 1);
    check("hreq_pc", int'(PC), 7);
    idle(); tick(); tick();
    check("halted_pc", int'(PC), 7);
    check("halted_ct", int'(cycle_ct), saved_ct + 4);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
